// File: rtl/psram_dev_resp.sv
// PSRAM link responder: oversampled SPI/QPI target that maps
// read, write and ID commands onto a synchronous byte-wide memory port.
module psram_dev_resp #(
    parameter int          ADDR_WIDTH = 24,
    parameter int          WAIT_CYC   = 6,
    parameter logic [31:0] ID_WORD    = 32'h0D5D_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sck_i,
    input  logic                  ce_n_i,
    input  logic [3:0]            sio_i,
    output logic [3:0]            sio_o,
    output logic [3:0]            sio_oe_o,
    output logic                  qpi_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    input  logic [7:0]            mem_rdata_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;
    localparam logic [2:0] S_WDATA  = 3'd5;
    localparam logic [2:0] S_ID     = 3'd6;
    localparam logic [2:0] S_IGNORE = 3'd7;

    localparam int AQ = (ADDR_WIDTH + 3) / 4;

    logic       sck_m, sck_s, sck_q;
    logic       ce_m, ce_s, ce_q;
    logic [3:0] sio_m, sio_s;
    logic       sck_rise, sck_fall, ce_rise, ce_fall;

    logic [2:0]            state;
    logic [7:0]            cnt;
    logic [7:0]            cmd;
    logic                  cmd_ok;
    logic                  armed;
    logic                  quad;
    logic                  rd;
    logic                  fast;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            wsh;
    logic [7:0]            rsh;
    logic [7:0]            pf;
    logic                  re_d;
    logic [31:0]           idsh;

    logic [7:0]            cmd_nx;
    logic                  cmd_last;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  addr_last;
    logic [7:0]            wsh_nx;
    logic                  byte_last;
    logic [7:0]            rcur;

    logic [2:0] dec_state;
    logic       dec_quad;
    logic       dec_rd;
    logic       dec_fast;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_m <= 1'b0;
            sck_s <= 1'b0;
            sck_q <= 1'b0;
            ce_m  <= 1'b0;
            ce_s  <= 1'b0;
            ce_q  <= 1'b0;
            sio_m <= 4'h0;
            sio_s <= 4'h0;
        end else begin
            sck_m <= sck_i;
            sck_s <= sck_m;
            sck_q <= sck_s;
            ce_m  <= ce_n_i;
            ce_s  <= ce_m;
            ce_q  <= ce_s;
            sio_m <= sio_i;
            sio_s <= sio_m;
        end
    end

    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign ce_rise  = ce_s & ~ce_q;
    assign ce_fall  = ~ce_s & ce_q;

    assign cmd_nx    = qpi_o ? {cmd[3:0], sio_s} : {cmd[6:0], sio_s[0]};
    assign cmd_last  = (cnt == (qpi_o ? 8'd1 : 8'd7));
    assign addr_nx   = quad ? ADDR_WIDTH'({addr, sio_s})
                            : ADDR_WIDTH'({addr, sio_s[0]});
    assign addr_inc  = addr + ADDR_WIDTH'(1);
    assign addr_last = (cnt == (quad ? 8'(AQ - 1) : 8'(ADDR_WIDTH - 1)));
    assign wsh_nx    = quad ? {wsh[3:0], sio_s} : {wsh[6:0], sio_s[0]};
    assign byte_last = (cnt == (quad ? 8'd1 : 8'd7));
    // first byte may arrive in the same cycle as the first data fall
    assign rcur      = (cnt == 8'd0) ? (re_d ? mem_rdata_i : pf) : rsh;

    always_comb begin
        dec_state = S_IGNORE;
        dec_quad  = qpi_o;
        dec_rd    = 1'b0;
        dec_fast  = 1'b0;
        case (cmd_nx)
            8'h03: begin
                if (!qpi_o) begin
                    dec_state = S_ADDR;
                    dec_rd    = 1'b1;
                end
            end
            8'h0B: begin
                dec_state = S_ADDR;
                dec_rd    = 1'b1;
                dec_fast  = 1'b1;
            end
            8'hEB: begin
                dec_state = S_ADDR;
                dec_rd    = 1'b1;
                dec_fast  = 1'b1;
                dec_quad  = 1'b1;
            end
            8'h02: dec_state = S_ADDR;
            8'h38: begin
                dec_state = S_ADDR;
                dec_quad  = 1'b1;
            end
            8'h9F: begin
                if (!qpi_o) dec_state = S_ID;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            cmd         <= 8'd0;
            cmd_ok      <= 1'b0;
            armed       <= 1'b0;
            quad        <= 1'b0;
            rd          <= 1'b0;
            fast        <= 1'b0;
            addr        <= '0;
            wsh         <= 8'd0;
            rsh         <= 8'd0;
            pf          <= 8'd0;
            re_d        <= 1'b0;
            idsh        <= 32'd0;
            sio_o       <= 4'h0;
            sio_oe_o    <= 4'h0;
            qpi_o       <= 1'b0;
            mem_re_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= 8'd0;
        end else begin
            mem_re_o <= 1'b0;
            mem_we_o <= 1'b0;
            re_d     <= mem_re_o;
            if (re_d) pf <= mem_rdata_i;
            if (ce_rise) begin
                state    <= S_IDLE;
                sio_o    <= 4'h0;
                sio_oe_o <= 4'h0;
                cmd_ok   <= 1'b0;
                // mode changes only land once the frame is closed
                if (cmd_ok) begin
                    case (cmd)
                        8'h35: qpi_o <= 1'b1;
                        8'hF5: qpi_o <= 1'b0;
                        8'h99: if (armed) qpi_o <= 1'b0;
                        default: ;
                    endcase
                end
                armed <= cmd_ok && (cmd == 8'h66);
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ce_fall) begin
                            state  <= S_CMD;
                            cnt    <= 8'd0;
                            cmd_ok <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            cmd <= cmd_nx;
                            cnt <= cnt + 8'd1;
                            if (cmd_last) begin
                                cmd_ok <= 1'b1;
                                cnt    <= 8'd0;
                                state  <= dec_state;
                                quad   <= dec_quad;
                                rd     <= dec_rd;
                                fast   <= dec_fast;
                                idsh   <= ID_WORD;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sck_rise) begin
                            addr <= addr_nx;
                            cnt  <= cnt + 8'd1;
                            if (addr_last) begin
                                cnt <= 8'd0;
                                if (!rd) begin
                                    state <= S_WDATA;
                                end else if (fast && WAIT_CYC > 0) begin
                                    state <= S_WAIT;
                                end else begin
                                    state      <= S_RDATA;
                                    mem_re_o   <= 1'b1;
                                    mem_addr_o <= addr_nx;
                                end
                            end
                        end
                    end
                    S_WAIT: begin
                        if (sck_rise) begin
                            cnt <= cnt + 8'd1;
                            if (cnt == 8'(WAIT_CYC - 1)) begin
                                cnt        <= 8'd0;
                                state      <= S_RDATA;
                                mem_re_o   <= 1'b1;
                                mem_addr_o <= addr;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (sck_fall) begin
                            sio_oe_o <= quad ? 4'hF : 4'b0010;
                            sio_o    <= quad ? rcur[7:4]
                                             : {2'b00, rcur[7], 1'b0};
                            rsh      <= quad ? {rcur[3:0], 4'h0}
                                             : {rcur[6:0], 1'b0};
                            cnt      <= byte_last ? 8'd0 : cnt + 8'd1;
                            // prefetch as the last slice of a byte leaves
                            if (byte_last) begin
                                mem_re_o   <= 1'b1;
                                addr       <= addr_inc;
                                mem_addr_o <= addr_inc;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (sck_rise) begin
                            wsh <= wsh_nx;
                            cnt <= cnt + 8'd1;
                            if (byte_last) begin
                                cnt         <= 8'd0;
                                mem_we_o    <= 1'b1;
                                mem_wdata_o <= wsh_nx;
                                mem_addr_o  <= addr;
                                addr        <= addr_inc;
                            end
                        end
                    end
                    S_ID: begin
                        if (sck_fall) begin
                            sio_oe_o <= 4'b0010;
                            sio_o    <= {2'b00, idsh[31], 1'b0};
                            idsh     <= {idsh[30:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_dev_resp.sv
// Directed bench for psram_dev_resp: a host drives link frames while a
// scoreboard checks memory strobes and returned data against expectations.
module tb_psram_dev_resp;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        sck = 1'b0;
    logic        ce_n = 1'b1;
    logic [3:0]  sio = 4'h0;
    logic [3:0]  sio_o;
    logic [3:0]  sio_oe_o;
    logic        qpi_o;
    logic        mem_re_o;
    logic        mem_we_o;
    logic [23:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  mem [0:4095];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_wr [$];
    logic [23:0] exp_rd [$];
    logic [7:0]  exp_rx [$];

    logic [3:0]  q, oe;
    logic [7:0]  b;
    logic        ok;

    always #5 clk = ~clk;

    psram_dev_resp #(
        .ADDR_WIDTH (24),
        .WAIT_CYC   (6),
        .ID_WORD    (32'h0D5D_0000)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .sck_i       (sck),
        .ce_n_i      (ce_n),
        .sio_i       (sio),
        .sio_o       (sio_o),
        .sio_oe_o    (sio_oe_o),
        .qpi_o       (qpi_o),
        .mem_re_o    (mem_re_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_re_o) mem_rdata <= mem[mem_addr_o[11:0]];
        if (mem_we_o) mem[mem_addr_o[11:0]] <= mem_wdata_o;
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (mem_we_o) begin
            e = (exp_wr.size() != 0) ? exp_wr.pop_front() : 'x;
            checks++;
            assert ({mem_addr_o, mem_wdata_o} === e) else begin
                errors++;
                $error("FAIL mem_we: got %h expected %h",
                       {mem_addr_o, mem_wdata_o}, e);
            end
        end
        if (mem_re_o) begin
            e = (exp_rd.size() != 0) ? {8'h00, exp_rd.pop_front()} : 'x;
            checks++;
            assert ({8'h00, mem_addr_o} === e) else begin
                errors++;
                $error("FAIL mem_re: got %h expected %h",
                       {8'h00, mem_addr_o}, e);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rx_check(input string tag, input logic [7:0] got);
        logic [7:0] e;
        e = (exp_rx.size() != 0) ? exp_rx.pop_front() : 'x;
        check(tag, {24'h0, got}, {24'h0, e});
    endtask

    task automatic tick(input logic [3:0] d, output logic [3:0] qo,
                        output logic [3:0] oeo);
        @(negedge clk);
        sck = 1'b0;
        sio = d;
        repeat (3) @(negedge clk);
        @(negedge clk);
        qo  = sio_o;
        oeo = sio_oe_o;
        sck = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_begin();
        @(negedge clk);
        ce_n = 1'b0;
        sck  = 1'b0;
        sio  = 4'h0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        sck = 1'b0;
        sio = 4'h0;
        repeat (4) @(negedge clk);
        ce_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic tx_spi(input logic [7:0] v);
        logic [3:0] tq, toe;
        for (int i = 7; i >= 0; i--) tick({3'b000, v[i]}, tq, toe);
    endtask

    task automatic tx_nib(input logic [3:0] v);
        logic [3:0] tq, toe;
        tick(v, tq, toe);
    endtask

    task automatic tx_addr(input logic [23:0] a, input logic qd);
        logic [3:0] tq, toe;
        if (qd) begin
            for (int i = 5; i >= 0; i--) tick(a[i*4 +: 4], tq, toe);
        end else begin
            for (int i = 23; i >= 0; i--) tick({3'b000, a[i]}, tq, toe);
        end
    endtask

    task automatic dummy(input int n, output logic all_off);
        logic [3:0] tq, toe;
        all_off = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick(4'h0, tq, toe);
            if (toe !== 4'h0) all_off = 1'b0;
        end
    endtask

    task automatic rx_byte(input logic qd, output logic [7:0] v,
                           output logic oe_ok);
        logic [3:0] tq, toe;
        v = 8'h00;
        oe_ok = 1'b1;
        for (int i = 0; i < (qd ? 2 : 8); i++) begin
            tick(4'h0, tq, toe);
            v = qd ? {v[3:0], tq} : {v[6:0], tq[1]};
            if (toe !== (qd ? 4'hF : 4'b0010)) oe_ok = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'hFFF] = 8'h96;
        mem[12'h000] = 8'hC3;
        mem[12'h001] = 8'h4B;

        repeat (3) @(negedge clk);
        check("reset_link", {23'h0, sio_o, sio_oe_o, qpi_o}, 32'h0);
        check("reset_mem", {mem_re_o, mem_we_o, mem_wdata_o, mem_addr_o[21:0]},
              32'h0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk);

        exp_wr.push_back({24'h000010, 8'hA5});
        exp_wr.push_back({24'h000011, 8'h3C});
        frame_begin();
        tx_spi(8'h02);
        tx_addr(24'h000010, 1'b0);
        tx_spi(8'hA5);
        tx_spi(8'h3C);
        frame_end();

        exp_rd.push_back(24'h000010);
        exp_rd.push_back(24'h000011);
        exp_rd.push_back(24'h000012);
        exp_rx.push_back(8'hA5);
        exp_rx.push_back(8'h3C);
        frame_begin();
        tx_spi(8'h03);
        tx_addr(24'h000010, 1'b0);
        check("spi_rd_oe_addr", {28'h0, sio_oe_o}, 32'h0);
        rx_byte(1'b0, b, ok);
        rx_check("spi_rd_b0", b);
        check("spi_rd_oe_b0", {31'h0, ok}, 32'h1);
        rx_byte(1'b0, b, ok);
        rx_check("spi_rd_b1", b);
        check("spi_rd_oe_b1", {31'h0, ok}, 32'h1);
        frame_end();
        check("spi_rd_oe_idle", {28'h0, sio_oe_o}, 32'h0);

        exp_rx.push_back(8'h0D);
        exp_rx.push_back(8'h5D);
        exp_rx.push_back(8'h00);
        exp_rx.push_back(8'h00);
        exp_rx.push_back(8'h00);
        frame_begin();
        tx_spi(8'h9F);
        for (int i = 0; i < 5; i++) begin
            rx_byte(1'b0, b, ok);
            rx_check($sformatf("id_b%0d", i), b);
        end
        frame_end();

        frame_begin();
        tx_spi(8'h5A);
        dummy(16, ok);
        check("ignore_oe", {31'h0, ok}, 32'h1);
        frame_end();

        frame_begin();
        tx_spi(8'h35);
        frame_end();
        check("qpi_enter", {31'h0, qpi_o}, 32'h1);

        exp_rd.push_back(24'hFFFFFF);
        exp_rd.push_back(24'h000000);
        exp_rd.push_back(24'h000001);
        exp_rx.push_back(8'h96);
        exp_rx.push_back(8'hC3);
        frame_begin();
        tx_nib(4'hE);
        tx_nib(4'hB);
        tx_addr(24'hFFFFFF, 1'b1);
        dummy(6, ok);
        check("qrd_oe_wait", {31'h0, ok}, 32'h1);
        rx_byte(1'b1, b, ok);
        rx_check("qrd_b0", b);
        check("qrd_oe_b0", {31'h0, ok}, 32'h1);
        rx_byte(1'b1, b, ok);
        rx_check("qrd_b1", b);
        frame_end();

        exp_wr.push_back({24'h000100, 8'h7E});
        frame_begin();
        tx_nib(4'h3);
        tx_nib(4'h8);
        tx_addr(24'h000100, 1'b1);
        tx_nib(4'h7);
        tx_nib(4'hE);
        tx_nib(4'h4);
        frame_end();
        check("qwr_oe_idle", {28'h0, sio_oe_o}, 32'h0);

        frame_begin();
        tx_nib(4'h9);
        tx_nib(4'h9);
        frame_end();
        check("lone_99", {31'h0, qpi_o}, 32'h1);
        frame_begin();
        tx_nib(4'h6);
        tx_nib(4'h6);
        frame_end();
        check("after_66", {31'h0, qpi_o}, 32'h1);
        frame_begin();
        tx_nib(4'h9);
        tx_nib(4'h9);
        frame_end();
        check("after_66_99", {31'h0, qpi_o}, 32'h0);

        frame_begin();
        tx_spi(8'h35);
        frame_end();
        check("qpi_reenter", {31'h0, qpi_o}, 32'h1);

        exp_rd.push_back(24'h000010);
        frame_begin();
        tx_nib(4'hE);
        tx_nib(4'hB);
        tx_addr(24'h000010, 1'b1);
        dummy(6, ok);
        tick(4'h0, q, oe);
        check("rst_pre_nib", {28'h0, q}, 32'hA);
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        check("rst_link", {23'h0, sio_o, sio_oe_o, qpi_o}, 32'h0);
        check("rst_mem", {6'h0, mem_re_o, mem_we_o, mem_wdata_o, mem_addr_o[15:0]},
              32'h0);
        ce_n = 1'b1;
        sck  = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_spi_mode", {31'h0, qpi_o}, 32'h0);

        exp_wr.push_back({24'h000020, 8'h5C});
        frame_begin();
        tx_spi(8'h02);
        tx_addr(24'h000020, 1'b0);
        tx_spi(8'h5C);
        frame_end();

        repeat (10) @(negedge clk);
        check("wr_queue_empty", exp_wr.size(), 32'h0);
        check("rd_queue_empty", exp_rd.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
